// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo frame loader: frame geometry, pixel and
// address widths, the loader state encoding and the raster address helper.
package stereo_pkg;

  localparam int IMG_W       = 128;
  localparam int IMG_H       = 16;
  localparam int PIX_W       = 3;
  localparam int ADDR_W      = 11;
  localparam int X_W         = 7;
  localparam int Y_W         = 4;
  localparam int SUM_W       = 14;
  localparam int FRAME_BEATS = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  // Memory address layout is {y, x} so a row is a contiguous 128-word block.
  function automatic logic [ADDR_W-1:0] raster_addr(input logic [Y_W-1:0] y,
                                                    input logic [X_W-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/frame_addr_cnt.sv
// Raster x/y counter for the frame loader. Holds the address of the next
// beat of a frame; a sof beat reloads it to pixel (1,0) because the sof beat
// itself is written at address 0. The last flag marks pixel (127,15).
module frame_addr_cnt
  import stereo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              sof_load,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;

  // Advance x-fastest; x wraps at the row end and carries into y.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (sof_load) begin
      x <= X_W'(1);
      y <= '0;
    end else if (step) begin
      if (x == X_W'(IMG_W - 1)) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign addr = raster_addr(y, x);
  assign last = (x == X_W'(IMG_W - 1)) && (y == Y_W'(IMG_H - 1));

endmodule

// File: rtl/frame_loader.sv
// Stereo frame loader: accepts left/right pixel pairs in raster order and
// writes one 128x16 frame into both image memories, then holds the frame
// (frame_ready) until the disparity engine acknowledges it.
// Optional feature: define FRAME_SUM_EN to add the f_sum output, the running
// sum of all left pixels of the current frame.
//
// state | meaning
// IDLE  | waiting for a sof beat; non-sof beats are consumed and dropped
// LOAD  | writing beats at the raster address; sof restarts the frame
// FULL  | frame complete, input stalled, waiting for frame_ack
module frame_loader
  import stereo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              pix_sof,
  input  logic [PIX_W-1:0]  pix_f,
  input  logic [PIX_W-1:0]  pix_g,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data_f,
  output logic [PIX_W-1:0]  wr_data_g,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              resync_err
`ifdef FRAME_SUM_EN
  ,
  output logic [SUM_W-1:0]  f_sum
`endif
);

  state_t            state;
  logic              accept;
  logic              sof_beat;
  logic              load_beat;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_last;

  // pix_ready is 0 in FULL, so no beat can be accepted there.
  assign accept    = pix_valid && pix_ready;
  assign sof_beat  = accept && pix_sof;
  assign load_beat = accept && !pix_sof && (state == LOAD);

  frame_addr_cnt u_addr_cnt (
    .clk      (clk),
    .rst      (rst),
    .step     (load_beat),
    .sof_load (sof_beat),
    .addr     (cnt_addr),
    .last     (cnt_last)
  );

  // Sequencing FSM; pix_ready follows the next state so it drops in the
  // same cycle FULL is entered, frame_ready trails FULL by one cycle so the
  // final write has landed before the frame is advertised.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pix_ready   <= 1'b0;
      frame_ready <= 1'b0;
      resync_err  <= 1'b0;
    end else begin
      resync_err  <= 1'b0;
      frame_ready <= 1'b0;
      case (state)
        IDLE: begin
          pix_ready <= 1'b1;
          if (sof_beat) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          pix_ready <= 1'b1;
          if (sof_beat) begin
            resync_err <= 1'b1;
          end else if (load_beat && cnt_last) begin
            state     <= FULL;
            pix_ready <= 1'b0;
          end
        end
        FULL: begin
          if (frame_ack) begin
            state     <= IDLE;
            pix_ready <= 1'b1;
          end else begin
            pix_ready   <= 1'b0;
            frame_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          pix_ready <= 1'b0;
        end
      endcase
    end
  end

  // Registered memory write port; address and data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      we        <= 1'b0;
      wr_addr   <= '0;
      wr_data_f <= '0;
      wr_data_g <= '0;
    end else begin
      we <= sof_beat || load_beat;
      if (sof_beat || load_beat) begin
        wr_addr   <= sof_beat ? '0 : cnt_addr;
        wr_data_f <= pix_f;
        wr_data_g <= pix_g;
      end
    end
  end

`ifdef FRAME_SUM_EN
  // Left-pixel sum: restarts with the sof pixel, frozen outside LOAD beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_sum <= '0;
    end else if (sof_beat) begin
      f_sum <= SUM_W'(pix_f);
    end else if (load_beat) begin
      f_sum <= f_sum + SUM_W'(pix_f);
    end
  end
`endif

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: directed sequence with random pixel data and gaps,
// checked each cycle against a frame-level behavioural model.
module tb_frame_loader;

  localparam int NBEATS = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        pix_sof = 1'b0;
  logic [2:0]  pix_f = '0;
  logic [2:0]  pix_g = '0;
  logic        we;
  logic [10:0] wr_addr;
  logic [2:0]  wr_data_f;
  logic [2:0]  wr_data_g;
  logic        frame_ready;
  logic        frame_ack = 1'b0;
  logic        resync_err;
`ifdef FRAME_SUM_EN
  logic [13:0] f_sum;
`endif

  always #5 clk = ~clk;

  frame_loader dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_sof     (pix_sof),
    .pix_f       (pix_f),
    .pix_g       (pix_g),
    .we          (we),
    .wr_addr     (wr_addr),
    .wr_data_f   (wr_data_f),
    .wr_data_g   (wr_data_g),
    .frame_ready (frame_ready),
    .frame_ack   (frame_ack),
    .resync_err  (resync_err)
`ifdef FRAME_SUM_EN
    ,
    .f_sum       (f_sum)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: a frame is "waiting", "loading at position pos" or
  // "complete for full_age cycles"; outputs are what the next cycle shows.
  typedef enum {M_IDLE, M_LOAD, M_FULL} mmode_t;
  mmode_t m_mode     = M_IDLE;
  int     m_pos      = 0;
  int     m_full_age = 0;
  bit     m_ready    = 0;
  bit     m_we       = 0;
  int     m_addr     = 0;
  int     m_f        = 0;
  int     m_g        = 0;
  bit     m_fr       = 0;
  bit     m_rs       = 0;
  int     m_sum      = 0;

  int wlog_addr[$];
  int wlog_f[$];
  int wlog_g[$];
  int rs_pulses = 0;
  int df[NBEATS];
  int dg[NBEATS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit s, input int f, input int g, input bit a);
    bit acc;
    rst = r; pix_valid = v; pix_sof = s; pix_f = 3'(f); pix_g = 3'(g); frame_ack = a;
    if (r) begin
      m_mode = M_IDLE; m_pos = 0; m_full_age = 0; m_ready = 0; m_we = 0;
      m_addr = 0; m_f = 0; m_g = 0; m_fr = 0; m_rs = 0; m_sum = 0;
    end else begin
      acc = v && m_ready;
      m_we = 0; m_rs = 0;
      if (m_mode == M_FULL) begin
        if (a) m_mode = M_IDLE;
        else m_full_age++;
      end else if (acc && s) begin
        m_we = 1; m_addr = 0; m_f = f; m_g = g;
        m_rs = (m_mode == M_LOAD);
        m_mode = M_LOAD; m_pos = 1; m_sum = f;
      end else if (acc && m_mode == M_LOAD) begin
        m_we = 1; m_addr = m_pos; m_f = f; m_g = g; m_sum += f;
        if (m_pos == NBEATS - 1) begin
          m_mode = M_FULL; m_full_age = 0;
        end
        m_pos = (m_pos + 1) % NBEATS;
      end
      m_ready = (m_mode != M_FULL);
      m_fr = (m_mode == M_FULL) && (m_full_age >= 1);
    end
    @(posedge clk);
    #1;
    chk("pix_ready", pix_ready, m_ready);
    chk("we", we, m_we);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data_f", wr_data_f, m_f);
    chk("wr_data_g", wr_data_g, m_g);
    chk("frame_ready", frame_ready, m_fr);
    chk("resync_err", resync_err, m_rs);
`ifdef FRAME_SUM_EN
    chk("f_sum", f_sum, m_sum);
`endif
    if (we === 1'b1) begin
      wlog_addr.push_back(int'(wr_addr));
      wlog_f.push_back(int'(wr_data_f));
      wlog_g.push_back(int'(wr_data_g));
    end
    if (resync_err === 1'b1) rs_pulses++;
  endtask

  task automatic clear_log();
    wlog_addr.delete(); wlog_f.delete(); wlog_g.delete();
  endtask

  // One frame from df/dg with sof on beat 0; optional random valid gaps and
  // random frame_ack while loading (which must be ignored).
  task automatic send_frame(input bit gaps);
    int i = 0;
    int guard = 0;
    bit v;
    bit a;
    bit acc;
    while (i < NBEATS && guard < 20000) begin
      v = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
      a = gaps ? bit'($urandom_range(0, 1)) : 1'b0;
      acc = v && m_ready;
      step(0, v, (i == 0), df[i], dg[i], a);
      if (acc) i++;
      guard++;
    end
    chk("frame_beats_within_budget", i, NBEATS);
  endtask

  task automatic load_beats(input int n);
    for (int k = 0; k < n; k++) begin
      step(0, 1, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), (k % 97) == 5);
    end
  endtask

  int qa[$];
  int qf[$];
  int qg[$];
  int mism;
  int rs0;

  initial begin
    // reset held with activity on the inputs
    for (int k = 0; k < 3; k++) step(1, 1, 1, 5, 6, 1);
    step(0, 0, 0, 0, 0, 0);

    // full frame, pix_f = addr % 8
    for (int k = 0; k < NBEATS; k++) begin
      df[k] = k % 8;
      dg[k] = int'($urandom_range(0, 7));
    end
    clear_log();
    send_frame(0);
    chk("fr_low_after_last_write", frame_ready, 0);
    step(0, 1, 1, 7, 7, 0);
    chk("fr_high_two_after_last", frame_ready, 1);
    mism = 0;
    for (int k = 0; k < wlog_addr.size(); k++) begin
      if (wlog_addr[k] != k || wlog_f[k] != k % 8 || wlog_g[k] != dg[k]) mism++;
    end
    chk("frame_write_count", wlog_addr.size(), NBEATS);
    chk("frame_write_order", mism, 0);
`ifdef FRAME_SUM_EN
    chk("f_sum_full_frame", f_sum, 7168);
`endif
    // FULL hold with valid/sof asserted, then ack with valid in the same cycle
    for (int k = 0; k < 4; k++) step(0, 1, k[0], 3, 4, 0);
    chk("full_no_writes", wlog_addr.size(), NBEATS);
    step(0, 1, 1, 2, 2, 1);
    chk("ready_after_ack", pix_ready, 1);
    chk("no_write_on_ack", we, 0);

    // non-sof beats in IDLE dropped, then sof beat at address 0
    clear_log();
    for (int k = 0; k < 5; k++) step(0, 1, 0, 6, 1, 0);
    step(0, 1, 1, 5, 3, 0);
    chk("idle_drop_writes", wlog_addr.size(), 1);
    chk("idle_sof_addr", wlog_addr[0], 0);

    // resync at beat 700, then 2047 more beats to FULL
    load_beats(699);
    rs0 = rs_pulses;
    step(0, 1, 1, 1, 2, 0);
    chk("resync_write_addr", wr_addr, 0);
    chk("resync_pulse", resync_err, 1);
    load_beats(NBEATS - 1);
    chk("resync_pulse_count", rs_pulses - rs0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("resync_frame_full", frame_ready, 1);
    step(0, 0, 0, 0, 0, 1);

    // same random data with and without valid gaps
    for (int k = 0; k < NBEATS; k++) begin
      df[k] = int'($urandom_range(0, 7));
      dg[k] = int'($urandom_range(0, 7));
    end
    clear_log();
    send_frame(0);
    step(0, 0, 0, 0, 0, 0);
    qa = wlog_addr; qf = wlog_f; qg = wlog_g;
    step(0, 0, 0, 0, 0, 1);
    clear_log();
    send_frame(1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("gap_write_count", wlog_addr.size(), qa.size());
    mism = 0;
    for (int k = 0; k < wlog_addr.size() && k < qa.size(); k++) begin
      if (wlog_addr[k] != qa[k] || wlog_f[k] != qf[k] || wlog_g[k] != qg[k]) mism++;
    end
    chk("gap_write_sequence", mism, 0);

    // reset at beat 1000 of a frame
    step(0, 1, 1, 4, 4, 0);
    load_beats(999);
    step(1, 1, 0, 7, 7, 0);
    step(1, 1, 0, 7, 7, 0);
    chk("rst_we", we, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_frame_ready", frame_ready, 0);
    clear_log();
    step(0, 1, 0, 3, 3, 0);
    chk("no_write_after_rst", we, 0);
    step(0, 1, 0, 3, 3, 0);
    step(0, 1, 1, 6, 2, 0);
    chk("post_rst_sof_addr", wr_addr, 0);
    chk("post_rst_write_count", wlog_addr.size(), 1);
    step(0, 1, 0, 1, 1, 0);
    chk("post_rst_second_addr", wr_addr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 The block SHALL have one clock and a reset; the reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 pix_valid  in  1  source holds one synchronized left/right pixel pair.
REQ-005 pix_ready  out  1  block accepts the beat this cycle; a beat transfers when pix_valid&&pix_ready.
REQ-006 pix_sof  in  1  beat is pixel (0,0) of a frame.
REQ-007 pix_f  in  3  left-camera pixel.
REQ-008 pix_g  in  3  right-camera pixel.
REQ-009 we  out  1  write strobe for both image memories.
REQ-010 wr_addr  out  11  memory address, {y[3:0], x[6:0]}.
REQ-011 wr_data_f  out  3  left-memory write data.
REQ-012 wr_data_g  out  3  right-memory write data.
REQ-013 frame_ready  out  1  level; both memories hold one complete frame.
REQ-014 frame_ack  in  1  disparity engine finished reading; releases the buffers.
REQ-015 resync_err  out  1  one-cycle pulse; a frame was restarted mid-load.

Function
REQ-016 Frame geometry SHALL be 128 x 16 pixels, raster order x-fastest, 2048 beats per frame.
REQ-017 States SHALL be IDLE, LOAD, and FULL.
REQ-018 IDLE: pix_ready=1; beats without pix_sof are consumed and discarded; a beat with pix_sof is written at address 0 and the state moves to LOAD with the next address 1.
REQ-019 LOAD: pix_ready=1; each accepted beat is written at the current address and the address increments; x wraps 127->0 and increments y.
REQ-020 LOAD, accepted beat with pix_sof: the beat is written at address 0, the next address is 1, and resync_err pulses on the following cycle.
REQ-021 LOAD, beat accepted at address 2047: the state moves to FULL.
REQ-022 FULL: pix_ready=0, no writes, frame_ready=1; frame_ack moves the state to IDLE on the next edge.
REQ-023 frame_ack outside FULL SHALL be ignored.
REQ-024 Write latency SHALL be one cycle: a beat accepted at cycle N produces registered we/wr_addr/wr_data at N+1.
REQ-025 frame_ready SHALL rise at N+2 for a final beat accepted at N, so the last write has already completed.
REQ-026 During FULL, pix_sof and pix_valid SHALL have no effect.
REQ-027 frame_ack and pix_valid in the same FULL cycle: no beat is accepted; pix_ready=1 from the next cycle.
REQ-028 we SHALL be 0 in every cycle not following an accepted beat; wr_addr/wr_data hold their last value.

Reset
REQ-029 While rst=1 the block SHALL hold: state=IDLE, address=0, we=0, wr_addr=0, wr_data_f=0, wr_data_g=0, frame_ready=0, resync_err=0, pix_ready=0.
REQ-030 Reset mid-LOAD or mid-FULL SHALL discard the partial or held frame, and no write is issued in the cycle after reset.

Configuration
REQ-031 Macro FRAME_SUM_EN: when defined, output f_sum (out, 14 bits) SHALL equal the sum of all left pixels of the current frame.
REQ-032 With FRAME_SUM_EN, f_sum SHALL clear on the sof beat, accumulate on each accepted LOAD beat, and be stable while frame_ready=1; its maximum is 14336.
REQ-033 Without FRAME_SUM_EN, the f_sum port and accumulator SHALL be absent, and all other behaviour is identical.

Structure
REQ-034 Package stereo_pkg SHALL hold IMG_W=128, IMG_H=16, PIX_W=3, ADDR_W=11, and the state enum.
REQ-035 One sub-module, frame_addr_cnt, SHALL provide the x/y raster counter with wrap, sof-reload, and last-pixel flag.

Verification
REQ-036 The bench SHALL cover: 2048 beats with sof on the first and pix_f=addr%8 -> 2048 writes at addresses 0..2047, frame_ready high 2 cycles after the last beat, f_sum=7168 when FRAME_SUM_EN is defined.
REQ-037 The bench SHALL cover: 5 beats without sof in IDLE, then a sof beat -> only the sof beat is written, at address 0.
REQ-038 The bench SHALL cover: sof reasserted at beat 700 of LOAD -> write to address 0, resync_err pulse, then 2047 more beats to reach FULL.
REQ-039 The bench SHALL cover: pix_valid held high in FULL -> pix_ready=0 and no writes; frame_ack -> IDLE next cycle and pix_ready=1.
REQ-040 The bench SHALL cover: rst at beat 1000 -> outputs at reset values, and the next frame starts at address 0 after a sof beat.
REQ-041 The bench SHALL cover: random pix_valid gaps (50% duty) -> identical write sequence to the gap-free run.
